// File: rtl/hazard_pkg.sv
// Shared encodings for the multi-cycle hazard unit and its MDU sequencer.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_IMM  = 2'b11
  } wb_sel_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_e;

  // MEM is the younger producer, so it outranks WB.
  function automatic fwd_sel_e fwd_pick(input logic mem_hit, input logic wb_hit);
    if (mem_hit)     return FWD_MEM;
    else if (wb_hit) return FWD_WB;
    else             return FWD_NONE;
  endfunction

endpackage

// File: rtl/mdu_seq.sv
// MDU sequencer: holds the front of the pipe for MDU_LAT-1 cycles per mul/div op.
module mdu_seq
  import hazard_pkg::*;
#(
  parameter int unsigned MDU_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mdu_start_ex,
  output logic stall_mdu,
  output logic mdu_busy,
  output logic mdu_done
);

  localparam bit          MULTI    = (MDU_LAT > 1);
  localparam int unsigned CW       = MULTI ? $clog2(MDU_LAT) : 1;
  localparam int unsigned CNT_LOAD = MULTI ? MDU_LAT - 2 : 0;

  mdu_state_e    state;
  logic [CW-1:0] cnt;
  logic          start;

  // Start is masked by reset so an op held in EX cannot stall while rst_n is low.
  assign start = mdu_start_ex & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && MULTI) begin
            state <= BUSY;
            cnt   <= CW'(CNT_LOAD);
          end
        end
        BUSY: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    stall_mdu = 1'b0;
    mdu_done  = 1'b0;
    case (state)
      IDLE: begin
        stall_mdu = start & MULTI;
        mdu_done  = start & ~MULTI;
      end
      BUSY: begin
        stall_mdu = (cnt != '0);
        mdu_done  = (cnt == '0);
      end
      default: ;
    endcase
  end

  assign mdu_busy = (state == BUSY);

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard unit: forwarding, load-use stall, branch flush and multi-cycle MDU hold.
// Optional perf counters enabled by HAZARD_UNIT_MC_PERF_EN.
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned MDU_LAT = 4,
  parameter int unsigned PERF_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rf_en_mem,
  input  logic              rf_en_wb,
  input  logic [REG_AW-1:0] rd_mem,
  input  logic [REG_AW-1:0] rd_wb,
  input  logic [REG_AW-1:0] rs1_ex,
  input  logic [REG_AW-1:0] rs2_ex,
  input  logic [REG_AW-1:0] rd_ex,
  input  logic [1:0]        sel_wb_ex,
  input  logic              mdu_start_ex,
  input  logic [REG_AW-1:0] rs1_id,
  input  logic [REG_AW-1:0] rs2_id,
  input  logic              rs1_used_id,
  input  logic              rs2_used_id,
  input  logic              br_taken,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              stall_if,
  output logic              stall_id,
  output logic              stall_ex,
  output logic              flush_id,
  output logic              flush_ex,
  output logic              flush_mem,
  output logic              mdu_busy,
  output logic              mdu_done
`ifdef HAZARD_UNIT_MC_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_flush_cnt
`endif
);

  if (MDU_LAT < 1 || PERF_W < 1) begin : g_bad_param
    $error("hazard_unit_mc: MDU_LAT and PERF_W must be at least 1");
  end

  fwd_sel_e fwd_a;
  fwd_sel_e fwd_b;
  logic     stall_lw;
  logic     stall_mdu;

  always_comb begin
    fwd_a = fwd_pick(rf_en_mem && rd_mem == rs1_ex && rs1_ex != '0,
                     rf_en_wb  && rd_wb  == rs1_ex && rs1_ex != '0);
    fwd_b = fwd_pick(rf_en_mem && rd_mem == rs2_ex && rs2_ex != '0,
                     rf_en_wb  && rd_wb  == rs2_ex && rs2_ex != '0);
  end

  assign forward_a = fwd_a;
  assign forward_b = fwd_b;

  assign stall_lw = (sel_wb_ex == WB_LOAD) && (rd_ex != '0) &&
                    ((rs1_used_id && rs1_id == rd_ex) ||
                     (rs2_used_id && rs2_id == rd_ex));

  mdu_seq #(
    .MDU_LAT (MDU_LAT)
  ) u_mdu_seq (
    .clk          (clk),
    .rst_n        (rst_n),
    .mdu_start_ex (mdu_start_ex),
    .stall_mdu    (stall_mdu),
    .mdu_busy     (mdu_busy),
    .mdu_done     (mdu_done)
  );

  // During an MDU hold ID/EX keeps the op, so the load-use bubble is withheld.
  assign stall_if  = stall_lw | stall_mdu;
  assign stall_id  = stall_lw | stall_mdu;
  assign stall_ex  = stall_mdu;
  assign flush_mem = stall_mdu;
  assign flush_ex  = (stall_lw & ~stall_mdu) | br_taken;
  assign flush_id  = br_taken;

`ifdef HAZARD_UNIT_MC_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_if && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
      if (br_taken && perf_flush_cnt != '1) perf_flush_cnt <= perf_flush_cnt + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc; a second instance covers MDU_LAT=1 and a narrow PERF_W.
`timescale 1ns/1ps
module tb_hazard_unit_mc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rf_en_mem, rf_en_wb;
  logic [4:0] rd_mem, rd_wb, rs1_ex, rs2_ex, rd_ex, rs1_id, rs2_id;
  logic [1:0] sel_wb_ex;
  logic       mdu_start_ex, rs1_used_id, rs2_used_id, br_taken;

  logic [1:0] forward_a, forward_b, forward_a1, forward_b1;
  logic stall_if, stall_id, stall_ex, flush_id, flush_ex, flush_mem, mdu_busy, mdu_done;
  logic stall_if1, stall_id1, stall_ex1, flush_id1, flush_ex1, flush_mem1, mdu_busy1, mdu_done1;
`ifdef HAZARD_UNIT_MC_PERF_EN
  logic [15:0] perf_stall_cnt, perf_flush_cnt;
  logic [2:0]  perf_stall_cnt1, perf_flush_cnt1;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_unit_mc dut (
    .clk(clk), .rst_n(rst_n), .rf_en_mem(rf_en_mem), .rf_en_wb(rf_en_wb),
    .rd_mem(rd_mem), .rd_wb(rd_wb), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
    .sel_wb_ex(sel_wb_ex), .mdu_start_ex(mdu_start_ex), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id), .br_taken(br_taken),
    .forward_a(forward_a), .forward_b(forward_b), .stall_if(stall_if), .stall_id(stall_id),
    .stall_ex(stall_ex), .flush_id(flush_id), .flush_ex(flush_ex), .flush_mem(flush_mem),
    .mdu_busy(mdu_busy), .mdu_done(mdu_done)
`ifdef HAZARD_UNIT_MC_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  hazard_unit_mc #(.MDU_LAT(1), .PERF_W(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .rf_en_mem(rf_en_mem), .rf_en_wb(rf_en_wb),
    .rd_mem(rd_mem), .rd_wb(rd_wb), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
    .sel_wb_ex(sel_wb_ex), .mdu_start_ex(mdu_start_ex), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id), .br_taken(br_taken),
    .forward_a(forward_a1), .forward_b(forward_b1), .stall_if(stall_if1), .stall_id(stall_id1),
    .stall_ex(stall_ex1), .flush_id(flush_id1), .flush_ex(flush_ex1), .flush_mem(flush_mem1),
    .mdu_busy(mdu_busy1), .mdu_done(mdu_done1)
`ifdef HAZARD_UNIT_MC_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt1), .perf_flush_cnt(perf_flush_cnt1)
`endif
  );

  // A branch must never resolve while EX is held by an MDU op.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && br_taken === 1'b1 && (stall_ex === 1'b1 || stall_ex1 === 1'b1)) begin
      n_err++;
      $display("FAIL br_during_mdu_hold at %0t", $time);
    end
  end

  task automatic clear_inputs();
    rf_en_mem = 0; rf_en_wb = 0; rd_mem = 0; rd_wb = 0; rs1_ex = 0; rs2_ex = 0; rd_ex = 0;
    sel_wb_ex = 2'b00; mdu_start_ex = 0; rs1_id = 0; rs2_id = 0;
    rs1_used_id = 0; rs2_used_id = 0; br_taken = 0;
  endtask

  task automatic test_reset();
    logic [11:0] got;
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    got = {forward_a, forward_b, stall_if, stall_id, stall_ex, flush_id, flush_ex, flush_mem, mdu_busy, mdu_done};
    n_cmp++; if (got !== 12'b0) begin n_err++; $display("FAIL reset_outputs got=%b exp=%b", got, 12'b0); end
    got = {forward_a1, forward_b1, stall_if1, stall_id1, stall_ex1, flush_id1, flush_ex1, flush_mem1, mdu_busy1, mdu_done1};
    n_cmp++; if (got !== 12'b0) begin n_err++; $display("FAIL reset_outputs_lat1 got=%b exp=%b", got, 12'b0); end
`ifdef HAZARD_UNIT_MC_PERF_EN
    n_cmp++; if ({perf_stall_cnt, perf_flush_cnt} !== 32'd0) begin n_err++;
      $display("FAIL reset_perf got=%h/%h exp=0/0", perf_stall_cnt, perf_flush_cnt); end
`endif
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_forwarding();
    rd_mem = 5; rd_wb = 5; rf_en_mem = 1; rf_en_wb = 1; rs1_ex = 5; rs2_ex = 5;
    #1;
    n_cmp++; if (forward_a !== 2'b10) begin n_err++; $display("FAIL fwd_a_mem got=%b exp=10", forward_a); end
    n_cmp++; if (forward_b !== 2'b10) begin n_err++; $display("FAIL fwd_b_mem got=%b exp=10", forward_b); end
    rf_en_mem = 0; #1;
    n_cmp++; if (forward_a !== 2'b01) begin n_err++; $display("FAIL fwd_a_wb got=%b exp=01", forward_a); end
    n_cmp++; if (forward_b !== 2'b01) begin n_err++; $display("FAIL fwd_b_wb got=%b exp=01", forward_b); end
    rs1_ex = 0; #1;
    n_cmp++; if (forward_a !== 2'b00) begin n_err++; $display("FAIL fwd_a_x0 got=%b exp=00", forward_a); end
    rd_mem = 6; rf_en_mem = 1; rs2_ex = 6; #1;
    n_cmp++; if (forward_b !== 2'b10) begin n_err++; $display("FAIL fwd_b_mem_only got=%b exp=10", forward_b); end
    rf_en_wb = 0; rd_mem = 0; rs2_ex = 0; #1;
    n_cmp++; if (forward_b !== 2'b00) begin n_err++; $display("FAIL fwd_b_x0_mem got=%b exp=00", forward_b); end
    rd_mem = 9; rd_wb = 3; rf_en_wb = 1; rs1_ex = 3; rs2_ex = 4; #1;
    n_cmp++; if ({forward_a, forward_b} !== 4'b0100) begin n_err++;
      $display("FAIL fwd_split got=%b exp=0100", {forward_a, forward_b}); end
    clear_inputs(); #1;
  endtask

  task automatic test_load_use();
    logic [5:0] got;
    sel_wb_ex = 2'b01; rd_ex = 7; rs2_id = 7; rs2_used_id = 1; #1;
    got = {stall_if, stall_id, stall_ex, flush_ex, flush_mem, flush_id};
    n_cmp++; if (got !== 6'b110100) begin n_err++; $display("FAIL lu_rs2 got=%b exp=110100", got); end
    rs2_used_id = 0; #1;
    got = {stall_if, stall_id, stall_ex, flush_ex, flush_mem, flush_id};
    n_cmp++; if (got !== 6'b000000) begin n_err++; $display("FAIL lu_rs2_unused got=%b exp=000000", got); end
    rs2_used_id = 1; rd_ex = 0; rs2_id = 0; #1;
    got = {stall_if, stall_id, stall_ex, flush_ex, flush_mem, flush_id};
    n_cmp++; if (got !== 6'b000000) begin n_err++; $display("FAIL lu_x0 got=%b exp=000000", got); end
    rd_ex = 7; rs2_id = 7; sel_wb_ex = 2'b00; #1;
    got = {stall_if, stall_id, stall_ex, flush_ex, flush_mem, flush_id};
    n_cmp++; if (got !== 6'b000000) begin n_err++; $display("FAIL lu_not_load got=%b exp=000000", got); end
    sel_wb_ex = 2'b01; rs2_used_id = 0; rs1_id = 7; rs1_used_id = 1; #1;
    got = {stall_if, stall_id, stall_ex, flush_ex, flush_mem, flush_id};
    n_cmp++; if (got !== 6'b110100) begin n_err++; $display("FAIL lu_rs1 got=%b exp=110100", got); end
    clear_inputs(); #1;
  endtask

  task automatic test_mdu_single();
    logic [0:4] es = 5'b11100;
    logic [0:4] eb = 5'b01110;
    logic [0:4] ed = 5'b00010;
    logic [4:0] got, exp;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1 mdu_start_ex = (i < 4);
      @(negedge clk);
      got = {stall_ex, flush_mem, stall_if, mdu_busy, mdu_done};
      exp = {es[i], es[i], es[i], eb[i], ed[i]};
      n_cmp++; if (got !== exp) begin n_err++; $display("FAIL mdu_single_c%0d got=%b exp=%b", i + 1, got, exp); end
    end
  endtask

  task automatic test_back_to_back();
    logic [0:8] es = 9'b111011100;
    logic [0:8] eb = 9'b011101110;
    logic [0:8] ed = 9'b000100010;
    logic [3:0] got, exp;
    logic [2:0] got1, exp1;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1 mdu_start_ex = (i < 8);
      @(negedge clk);
      got = {stall_ex, flush_mem, mdu_busy, mdu_done};
      exp = {es[i], es[i], eb[i], ed[i]};
      n_cmp++; if (got !== exp) begin n_err++; $display("FAIL b2b_c%0d got=%b exp=%b", i + 1, got, exp); end
      got1 = {stall_ex1, mdu_busy1, mdu_done1};
      exp1 = {1'b0, 1'b0, (i < 8) ? 1'b1 : 1'b0};
      n_cmp++; if (got1 !== exp1) begin n_err++; $display("FAIL lat1_c%0d got=%b exp=%b", i + 1, got1, exp1); end
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [0:4] es = 5'b11100;
    logic [0:4] eb = 5'b01110;
    logic [0:4] ed = 5'b00010;
    logic [3:0] got, exp;
    @(posedge clk); #1 mdu_start_ex = 1;
    @(posedge clk); @(negedge clk);
    n_cmp++; if ({stall_ex, mdu_busy} !== 2'b11) begin n_err++;
      $display("FAIL rst_pre_busy got=%b exp=11", {stall_ex, mdu_busy}); end
    rst_n = 0; #1;
    got = {stall_ex, flush_mem, mdu_busy, mdu_done};
    n_cmp++; if (got !== 4'b0000) begin n_err++; $display("FAIL rst_abort got=%b exp=0000", got); end
    @(posedge clk); @(negedge clk);
    got = {stall_ex, flush_mem, mdu_busy, mdu_done};
    n_cmp++; if (got !== 4'b0000) begin n_err++; $display("FAIL rst_hold got=%b exp=0000", got); end
    @(posedge clk); #1 rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      mdu_start_ex = (i < 4);
      @(negedge clk);
      got = {stall_ex, flush_mem, mdu_busy, mdu_done};
      exp = {es[i], es[i], eb[i], ed[i]};
      n_cmp++; if (got !== exp) begin n_err++; $display("FAIL rst_rerun_c%0d got=%b exp=%b", i + 1, got, exp); end
    end
  endtask

  task automatic test_branch_flush();
    logic [5:0] got;
    #1 rst_n = 0; #1;
    @(posedge clk); #1 rst_n = 1;
    br_taken = 1; sel_wb_ex = 2'b01; rd_ex = 7; rs1_id = 7; rs1_used_id = 1; #1;
    got = {flush_id, flush_ex, stall_if, stall_id, stall_ex, flush_mem};
    n_cmp++; if (got !== 6'b111100) begin n_err++; $display("FAIL br_lu got=%b exp=111100", got); end
    @(posedge clk); @(negedge clk);
`ifdef HAZARD_UNIT_MC_PERF_EN
    n_cmp++; if ({perf_stall_cnt, perf_flush_cnt} !== {16'd1, 16'd1}) begin n_err++;
      $display("FAIL perf_first got=%0d/%0d exp=1/1", perf_stall_cnt, perf_flush_cnt); end
`endif
    repeat (9) @(posedge clk);
    @(negedge clk);
`ifdef HAZARD_UNIT_MC_PERF_EN
    n_cmp++; if ({perf_stall_cnt, perf_flush_cnt} !== {16'd10, 16'd10}) begin n_err++;
      $display("FAIL perf_ten got=%0d/%0d exp=10/10", perf_stall_cnt, perf_flush_cnt); end
    n_cmp++; if ({perf_stall_cnt1, perf_flush_cnt1} !== {3'd7, 3'd7}) begin n_err++;
      $display("FAIL perf_sat got=%0d/%0d exp=7/7", perf_stall_cnt1, perf_flush_cnt1); end
`endif
    rs1_used_id = 0; #1;
    got = {flush_id, flush_ex, stall_if, stall_id, stall_ex, flush_mem};
    n_cmp++; if (got !== 6'b110000) begin n_err++; $display("FAIL br_only got=%b exp=110000", got); end
    @(posedge clk); @(negedge clk);
`ifdef HAZARD_UNIT_MC_PERF_EN
    n_cmp++; if ({perf_stall_cnt, perf_flush_cnt} !== {16'd10, 16'd11}) begin n_err++;
      $display("FAIL perf_br_only got=%0d/%0d exp=10/11", perf_stall_cnt, perf_flush_cnt); end
`endif
    clear_inputs(); #1;
    got = {flush_id, flush_ex, stall_if, stall_id, stall_ex, flush_mem};
    n_cmp++; if (got !== 6'b000000) begin n_err++; $display("FAIL br_clear got=%b exp=000000", got); end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_mdu_single();
    test_back_to_back();
    test_reset_mid_busy();
    test_branch_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
